// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: 8-level priority interrupt sequencer with rotating
// priority, nested servicing and a two-pulse INTA handshake that yields
// an 8-bit vector {vector_base, level}.
// LTIM = 0 selects edge-triggered request capture, LTIM = 1 level-triggered.
// Optional macro AUTO_EOI_EN: the in-service bit is retired automatically on
// the second acknowledge; the eoi input keeps working alongside it.
module interrupt_sequencer #(
    parameter int LTIM = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic [4:0] vector_base,
    input  logic       rotate_en,
    input  logic       inta,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_req,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [2:0] lowest_prio
);

`ifdef AUTO_EOI_EN
    localparam bit AUTO_EOI = 1'b1;
`else
    localparam bit AUTO_EOI = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    state_t     state;
    logic [7:0] ir_prev;      // edge history for edge mode
    logic [7:0] lvl_blk;      // level mode: acked lines held off until ir drops
    logic [2:0] cur_lvl;
    logic       spurious;

    logic [3:0] cand;         // {found, level} of best unmasked request
    logic [3:0] isr_top;      // {found, level} of best in-service level
    logic       qualify;
    logic       eoi_vld;
    logic [2:0] eoi_lvl;
    logic       auto_vld;
    logic [7:0] isr_clr;
    logic [7:0] ack_mask;
    logic [7:0] isr_next;
    logic [2:0] lp_next;

    // Position of a level in the current rotation; 0 is the most urgent.
    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lowp);
        return lvl - lowp - 3'd1;
    endfunction

    // Highest-priority set bit, scanning from lowp+1 upward with wrap.
    function automatic logic [3:0] prio_pick(input logic [7:0] bits, input logic [2:0] lowp);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'h0;
        for (int k = 7; k >= 0; k--) begin
            idx = lowp + 3'd1 + 3'(k);
            if (bits[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign cand    = prio_pick(irr & ~imr, lowest_prio);
    assign isr_top = prio_pick(isr, lowest_prio);
    // A request only interrupts if it outranks everything already in service.
    assign qualify = cand[3] &&
                     (!isr_top[3] ||
                      (prio_rank(cand[2:0], lowest_prio) < prio_rank(isr_top[2:0], lowest_prio)));

    // EOI and auto-EOI clears are applied before the first-INTA isr set.
    always_comb begin
        eoi_vld = 1'b0;
        eoi_lvl = 3'd0;
        if (eoi) begin
            if (eoi_specific) begin
                eoi_vld = 1'b1;
                eoi_lvl = eoi_level;
            end else begin
                eoi_vld = isr_top[3];
                eoi_lvl = isr_top[2:0];
            end
        end
        auto_vld = AUTO_EOI && (state == ACK2) && inta && !spurious;
        isr_clr = 8'h00;
        if (eoi_vld)  isr_clr = isr_clr | (8'b1 << eoi_lvl);
        if (auto_vld) isr_clr = isr_clr | (8'b1 << cur_lvl);
        lp_next = lowest_prio;
        if (rotate_en) begin
            if (eoi_vld)       lp_next = eoi_lvl;
            else if (auto_vld) lp_next = cur_lvl;
        end
        ack_mask = 8'h00;
        if ((state == ACK1) && inta && cand[3]) ack_mask = 8'b1 << cand[2:0];
        isr_next = (isr & ~isr_clr) | ack_mask;
    end

    // Request capture: edge-latched or level-following, cleared on acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr     <= 8'h00;
            ir_prev <= 8'h00;
            lvl_blk <= 8'h00;
        end else begin
            ir_prev <= ir;
            if (LTIM != 0) begin
                lvl_blk <= (lvl_blk | ack_mask) & ir;
                irr     <= ir & ~((lvl_blk | ack_mask) & ir);
            end else begin
                irr     <= (irr & ~ack_mask) | (ir & ~ir_prev);
            end
        end
    end

    // Handshake FSM with registered int_req/vector, plus isr and rotation state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            int_req      <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
            isr          <= 8'h00;
            lowest_prio  <= 3'd7;
            cur_lvl      <= 3'd7;
            spurious     <= 1'b0;
        end else begin
            vector_valid <= 1'b0;
            isr          <= isr_next;
            lowest_prio  <= lp_next;
            case (state)
                IDLE: begin
                    if (qualify) begin
                        int_req <= 1'b1;
                        state   <= ACK1;
                    end
                end
                ACK1: begin
                    if (inta) begin
                        int_req <= 1'b0;
                        state   <= ACK2;
                        if (cand[3]) begin
                            cur_lvl  <= cand[2:0];
                            spurious <= 1'b0;
                        end else begin
                            cur_lvl  <= 3'd7;
                            spurious <= 1'b1;
                        end
                    end
                end
                ACK2: begin
                    if (inta) begin
                        vector       <= {vector_base, cur_lvl};
                        vector_valid <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
